drt_enumerator: RTL and testbench

- Wishbone master that walks the device ROM table (DRT) after reset or on request. It reads the header, then each device record, and streams the decoded records to the host-side consumer.
- Sits directly upstream of the DRT slave on the interconnect and is its only reader at boot.
- DRT layout: header of HEADER_WORDS words; word 0 = {id[31:16], version[15:0]}; word 1 = device count. Device i record starts at BASE_ADR + HEADER_WORDS + i*DEV_WORDS, with words id, info, mem_offset, size at offsets 0..3.

---
 rtl/drt_enumerator.sv | 212 +++++++++++++++++++++
 tb/tb_drt_enumerator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drt_enumerator.sv
// Wishbone master that walks the device ROM table (header, then one record per
// device) and streams each decoded record to a ready/valid consumer.
module drt_enumerator #(
  parameter logic [31:0] BASE_ADR     = 32'h0000_0000,
  parameter int unsigned HEADER_WORDS = 8,
  parameter int unsigned DEV_WORDS    = 8,
  parameter int unsigned MAX_DEVICES  = 16,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] drt_id,
  output logic [15:0] drt_version,
  output logic [31:0] num_devices,
  output logic        dev_valid,
  input  logic        dev_ready,
  output logic [7:0]  dev_index,
  output logic [31:0] dev_id,
  output logic [31:0] dev_info,
  output logic [31:0] dev_mem_off,
  output logic [31:0] dev_size,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_ACK, WAIT_REL, NEXT, EMIT, FINISH
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] version;
    logic [31:0] count;
    logic [31:0] dev_id;
    logic [31:0] dev_info;
    logic [31:0] dev_mem_off;
    logic [31:0] dev_size;
  } fields_t;

  state_t      state_q, state_d;
  fields_t     fld_q, fld_d;
  logic        in_hdr_q, in_hdr_d;
  logic [1:0]  word_q, word_d;
  logic [7:0]  dev_q, dev_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        error_q, error_d;
  logic [31:0] word_off;
  logic        tmo_expired;

  // Header words sit at the table base; device words follow at a fixed stride.
  assign word_off = in_hdr_q ? 32'(word_q)
                  : 32'(HEADER_WORDS) + 32'(dev_q) * 32'(DEV_WORDS) + 32'(word_q);
  assign tmo_expired = (tmo_q <= 8'd1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    fld_d    = fld_q;
    in_hdr_d = in_hdr_q;
    word_d   = word_q;
    dev_d    = dev_q;
    tmo_d    = tmo_q;
    error_d  = error_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          error_d  = 1'b0;
          fld_d    = '0;
          in_hdr_d = 1'b1;
          word_d   = 2'd0;
          dev_d    = 8'd0;
          state_d  = REQ;
        end
      end

      REQ: begin
        tmo_d   = 8'(TIMEOUT);
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (wbm_ack_i) begin
          if (in_hdr_q) begin
            if (word_q == 2'd0) {fld_d.id, fld_d.version} = wbm_dat_i;
            else                fld_d.count = wbm_dat_i;
          end else begin
            unique case (word_q)
              2'd0: fld_d.dev_id      = wbm_dat_i;
              2'd1: fld_d.dev_info    = wbm_dat_i;
              2'd2: fld_d.dev_mem_off = wbm_dat_i;
              2'd3: fld_d.dev_size    = wbm_dat_i;
              default: ;
            endcase
          end
          state_d = WAIT_REL;
        end else if (tmo_expired) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end

      // Same timeout budget keeps running while the slave releases ack.
      WAIT_REL: begin
        if (!wbm_ack_i) begin
          state_d = NEXT;
        end else if (tmo_expired) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end

      NEXT: begin
        state_d = REQ;
        if (in_hdr_q) begin
          if (word_q == 2'd0) begin
            word_d = 2'd1;
          end else if (fld_q.count == 32'd0) begin
            state_d = FINISH;
          end else if (fld_q.count > 32'(MAX_DEVICES)) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            in_hdr_d = 1'b0;
            word_d   = 2'd0;
            dev_d    = 8'd0;
          end
        end else if (word_q != 2'd3) begin
          word_d = word_q + 2'd1;
        end else begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (dev_ready) begin
          dev_d = dev_q + 8'd1;
          if (32'(dev_q) + 32'd1 == fld_q.count) begin
            state_d = FINISH;
          end else begin
            word_d  = 2'd0;
            state_d = REQ;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fld_q    <= '0;
      in_hdr_q <= 1'b0;
      word_q   <= 2'd0;
      dev_q    <= 8'd0;
      tmo_q    <= 8'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fld_q    <= fld_d;
      in_hdr_q <= in_hdr_d;
      word_q   <= word_d;
      dev_q    <= dev_d;
      tmo_q    <= tmo_d;
      error_q  <= error_d;
    end
  end

  // Bus and status outputs decode straight from the state register, so an
  // asynchronous reset drops cyc/stb immediately.
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign error       = error_q;
  assign drt_id      = fld_q.id;
  assign drt_version = fld_q.version;
  assign num_devices = fld_q.count;
  assign dev_valid   = (state_q == EMIT);
  assign dev_index   = dev_q;
  assign dev_id      = fld_q.dev_id;
  assign dev_info    = fld_q.dev_info;
  assign dev_mem_off = fld_q.dev_mem_off;
  assign dev_size    = fld_q.dev_size;

  assign wbm_cyc_o = (state_q == REQ) || (state_q == WAIT_ACK) || (state_q == WAIT_REL);
  assign wbm_stb_o = (state_q == REQ) || (state_q == WAIT_ACK);
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
  assign wbm_adr_o = wbm_cyc_o ? BASE_ADR + word_off : 32'h0;
  assign wbm_dat_o = 32'h0;

endmodule

// File: tb/tb_drt_enumerator.sv
// Bench for drt_enumerator: a behavioural Wishbone ROM slave, an address and
// record scoreboard, a table of scans, and hand-written multi-cycle sequences.
module tb_drt_enumerator;

  localparam int MAX_DEV     = 16;
  localparam int HUNG_CYC_HI = 256;  // one REQ cycle plus 255 waiting cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [15:0] drt_id, drt_version;
  logic [31:0] num_devices;
  logic        dev_valid, dev_ready;
  logic [7:0]  dev_index;
  logic [31:0] dev_id, dev_info, dev_mem_off, dev_size;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] id;
    logic [31:0] info;
    logic [31:0] mem_off;
    logic [31:0] size;
  } rec_t;

  typedef struct packed {
    logic [31:0] hdr0;
    logic [31:0] cnt;
    logic        exp_err;
    logic        poke;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:255];
  logic [31:0] exp_adr [$];
  rec_t        exp_rec [$];
  logic        hang_en;
  logic [31:0] hang_adr;
  logic        stb_prev = 1'b0;
  int          cyc_run = 0;
  int          last_cyc_len = 0;
  int          done_cnt = 0;
  int          extra_reads = 0;
  int          extra_recs = 0;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  drt_enumerator dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .drt_id(drt_id), .drt_version(drt_version), .num_devices(num_devices),
    .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_index(dev_index),
    .dev_id(dev_id), .dev_info(dev_info), .dev_mem_off(dev_mem_off), .dev_size(dev_size),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rec_word(input int i, input int k);
    logic [31:0] w [4];
    if (i == 0)      w = '{32'h0001_0001, 32'h1, 32'h0,   32'h100};
    else if (i == 1) w = '{32'h0002_0001, 32'h2, 32'h100, 32'h40};
    else             w = '{32'h0003_0000 + 32'(i), 32'(i), 32'h1000 * 32'(i), 32'h20 + 32'(i)};
    return w[k];
  endfunction

  // ROM slave: acks while cyc&stb are high, releases ack one cycle after stb falls.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= 32'h0;
    end else if (wbm_cyc_o && wbm_stb_o && !(hang_en && wbm_adr_o == hang_adr)) begin
      wbm_ack_i <= 1'b1;
      wbm_dat_i <= mem[wbm_adr_o[7:0]];
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  // Monitor, sampled on the falling edge: reads, record transfers, done pulses.
  always @(negedge clk) begin
    logic [31:0] ea;
    rec_t        er;
    stb_prev <= wbm_stb_o;
    if (wbm_cyc_o) cyc_run <= cyc_run + 1;
    else if (cyc_run != 0) begin
      last_cyc_len <= cyc_run;
      cyc_run      <= 0;
    end
    if (!rst) begin
      if (wbm_stb_o && !stb_prev) begin
        check("bus_attr", {wbm_we_o, wbm_sel_o, wbm_dat_o}, {1'b0, 4'hF, 32'h0});
        if (exp_adr.size() == 0) extra_reads <= extra_reads + 1;
        else begin
          ea = exp_adr.pop_front();
          check("read_adr", wbm_adr_o, ea);
        end
      end
      if (dev_valid && dev_ready) begin
        if (exp_rec.size() == 0) extra_recs <= extra_recs + 1;
        else begin
          er = exp_rec.pop_front();
          check("record", {dev_index, dev_id, dev_info, dev_mem_off, dev_size}, er);
        end
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic prepare(input logic [31:0] hdr0, input logic [31:0] cnt);
    rec_t r;
    mem[0] = hdr0;
    mem[1] = cnt;
    exp_adr.push_back(32'd0);
    exp_adr.push_back(32'd1);
    if (cnt != 0 && cnt <= MAX_DEV) begin
      for (int i = 0; i < int'(cnt); i++) begin
        for (int k = 0; k < 4; k++) exp_adr.push_back(32'(8 + 8 * i + k));
        r = '{idx: 8'(i), id: rec_word(i, 0), info: rec_word(i, 1),
              mem_off: rec_word(i, 2), size: rec_word(i, 3)};
        exp_rec.push_back(r);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("error_cleared", error, 1'b0);
  endtask

  task automatic wait_done(input logic [31:0] hdr0, input logic [31:0] cnt,
                           input logic exp_err, input logic poke, input int d0);
    int g = 0;
    while (!done && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("done_seen", done, 1'b1);
    if (poke) start = 1'b1;  // lands on the done cycle and must be ignored
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_idle", busy, 1'b0);
    check("error", error, exp_err);
    check("header", {drt_id, drt_version, num_devices}, {hdr0, cnt});
    check("reads_left", 32'(exp_adr.size()), 32'd0);
    check("recs_left", 32'(exp_rec.size()), 32'd0);
    check("extra_activity", {32'(extra_reads), 32'(extra_recs)}, 64'd0);
  endtask

  task automatic run_scan(input logic [31:0] hdr0, input logic [31:0] cnt,
                          input logic exp_err, input logic poke);
    int d0;
    prepare(hdr0, cnt);
    d0 = done_cnt;
    pulse_start();
    wait_done(hdr0, cnt, exp_err, poke, d0);
  endtask

  initial begin
    int   g, d0;
    rec_t rec0;
    logic stable_ok, bus_seen;

    vecs[0] = '{hdr0: 32'h0001_0001, cnt: 32'd2,          exp_err: 1'b0, poke: 1'b0};
    vecs[1] = '{hdr0: 32'hA5C3_0102, cnt: 32'd0,          exp_err: 1'b0, poke: 1'b1};
    vecs[2] = '{hdr0: 32'h1234_5678, cnt: 32'd17,         exp_err: 1'b1, poke: 1'b0};
    vecs[3] = '{hdr0: 32'h0BAD_0003, cnt: 32'd1,          exp_err: 1'b0, poke: 1'b0};
    vecs[4] = '{hdr0: 32'hFFFF_FFFF, cnt: 32'd16,         exp_err: 1'b0, poke: 1'b0};
    vecs[5] = '{hdr0: 32'h0000_8001, cnt: 32'h8000_0000,  exp_err: 1'b1, poke: 1'b0};

    for (int a = 0; a < 256; a++) mem[a] = 32'hDEAD_0000 | 32'(a);
    for (int i = 0; i < MAX_DEV; i++)
      for (int k = 0; k < 4; k++) mem[8 + 8 * i + k] = rec_word(i, k);

    rst = 1'b1; start = 1'b0; dev_ready = 1'b1; hang_en = 1'b0; hang_adr = 32'h0;
    #3;
    check("reset_outputs", |{busy, done, error, drt_id, drt_version, num_devices, dev_valid,
          dev_index, dev_id, dev_info, dev_mem_off, dev_size, wbm_cyc_o, wbm_stb_o,
          wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_scan(vecs[v].hdr0, vecs[v].cnt, vecs[v].exp_err, vecs[v].poke);

    // Slave never acks header word 1: abort after the timeout, then rescan.
    hang_en = 1'b1; hang_adr = 32'd1;
    mem[0] = 32'h0001_0001; mem[1] = 32'd2;
    exp_adr.push_back(32'd0);
    exp_adr.push_back(32'd1);
    d0 = done_cnt;
    pulse_start();
    wait_done(32'h0001_0001, 32'd0, 1'b1, 1'b0, d0);
    check("timeout_cyc_len", 32'(last_cyc_len), 32'(HUNG_CYC_HI));
    hang_en = 1'b0;
    run_scan(32'h0001_0001, 32'd2, 1'b0, 1'b0);

    // Consumer stalls record 0 for 50 cycles.
    dev_ready = 1'b0;
    prepare(32'h0001_0001, 32'd2);
    rec0 = exp_rec[0];
    d0 = done_cnt;
    pulse_start();
    g = 0;
    while (!dev_valid && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("bp_valid", dev_valid, 1'b1);
    stable_ok = 1'b1; bus_seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!dev_valid || {dev_index, dev_id, dev_info, dev_mem_off, dev_size} != rec0)
        stable_ok = 1'b0;
      if (wbm_cyc_o) bus_seen = 1'b1;
    end
    check("bp_stable", stable_ok, 1'b1);
    check("bp_no_bus", bus_seen, 1'b0);
    @(posedge clk); #1 dev_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_transfer", 32'(exp_rec.size()), 32'd1);
    @(negedge clk);
    check("bp_valid_drop", dev_valid, 1'b0);
    wait_done(32'h0001_0001, 32'd2, 1'b0, 1'b0, d0);

    // Reset while waiting for the ack of device 1 word 2.
    hang_en = 1'b1; hang_adr = 32'd18;
    prepare(32'h0001_0001, 32'd2);
    pulse_start();
    g = 0;
    while (!(wbm_stb_o && wbm_adr_o == 32'd18) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("reached_dev1_w2", {wbm_stb_o, wbm_adr_o}, {1'b1, 32'd18});
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("midreset_outputs", |{busy, done, error, drt_id, drt_version, num_devices, dev_valid,
          dev_index, dev_id, dev_info, dev_mem_off, dev_size, wbm_cyc_o, wbm_stb_o,
          wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, 1'b0);
    exp_adr.delete();
    exp_rec.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    hang_en = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_on_reset", 32'(done_cnt), 32'(d0));
    run_scan(32'h0001_0001, 32'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
